serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-shares one external 1-bit full-adder cell across a WIDTH-bit operation. It processes one bit per clock, LSB first, and feeds the cell's carry or borrow back on the next bit. It accepts operands with a start/busy/done handshake, then returns the result and the final carry or borrow. The block sits between a requesting controller and a single combinational full-adder cell with add/subtract mode select.

---
 rtl/serial_addsub_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer.
// Time-shares one external 1-bit full-adder cell across a WIDTH-bit operation.
// It processes one bit per clock, LSB first, and feeds the carry or borrow back
// into the cell on the next bit.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, mode, a, b request; mode 0 = a+b, 1 = a-b; operands latched with start
//   abort             cancel an operation in progress (RUN only)
//   busy, done        busy high in RUN; done pulses for one cycle on completion
//   result, carry_out last completed result and final carry (add) or borrow (sub)
//   fa_a, fa_b        operand bits to the cell
//   fa_pcarry         running carry/borrow into the cell
//   fa_cin            cell mode select
//   fa_sum, fa_ncarry combinational sum and carry/borrow returned by the cell
module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_pcarry,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_ncarry
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    result_d = result_q;
    cout_d   = cout_q;

    unique case (state_q)
      StIdle, StDone: begin
        // Start wins over abort in DONE; abort has no meaning outside RUN.
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          mode_d   = mode;
          sum_sr_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = StRun;
        end else begin
          state_d  = StIdle;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
          a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
          carry_d  = fa_ncarry;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // The sum register has just been filled with the final bit.
            result_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
            cout_d   = fa_ncarry;
            state_d  = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign fa_a      = a_sr_q[0];
  assign fa_b      = b_sr_q[0];
  assign fa_pcarry = carry_q;
  assign fa_cin    = mode_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl with a behavioural full-adder cell.
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk, rst_n, start, mode, abort;
  logic [WIDTH-1:0] a, b, result;
  logic             busy, done, carry_out;
  logic             fa_a, fa_b, fa_pcarry, fa_cin, fa_sum, fa_ncarry;

  int n_checks = 0;
  int n_fail   = 0;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_pcarry (fa_pcarry),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_ncarry (fa_ncarry)
  );

  // Full-adder cell following the sum/carry/borrow contract.
  assign fa_sum    = fa_a ^ fa_b ^ fa_pcarry;
  assign fa_ncarry = fa_cin ? ((~fa_a & fa_b) | (~fa_a & fa_pcarry) | (fa_b & fa_pcarry))
                            : ((fa_a & fa_b) | (fa_a & fa_pcarry) | (fa_b & fa_pcarry));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request at the negedge; returns #1 after the edge that samples it.
  task automatic issue(input logic m, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    n_checks++;
    if ({busy, done, result, carry_out, fa_a, fa_b, fa_pcarry, fa_cin} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b fa=%b%b%b%b, want all 0",
               busy, done, result, carry_out, fa_a, fa_b, fa_pcarry, fa_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one operation, checking busy for WIDTH cycles, a single-cycle done and the result.
  task automatic test_op(input string name, input logic m, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] exp_r,
                         input logic exp_c, input logic chk_pcarry);
    issue(m, av, bv);
    for (int i = 0; i < WIDTH; i++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || fa_cin !== m) begin
        n_fail++;
        $display("FAIL %s_run%0d: got busy=%b done=%b fa_cin=%b, want busy=1 done=0 fa_cin=%b",
                 name, i, busy, done, fa_cin, m);
      end
      if (chk_pcarry) begin
        n_checks++;
        if (fa_pcarry !== (i != 0)) begin
          n_fail++;
          $display("FAIL %s_pcarry%0d: got %b, want %b", name, i, fa_pcarry, (i != 0));
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_r || carry_out !== exp_c) begin
      n_fail++;
      $display("FAIL %s_done: got done=%b busy=%b result=%h cout=%b, want 1 0 %h %b",
               name, done, busy, result, carry_out, exp_r, exp_c);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: got done=%b busy=%b one cycle later, want 0 0", name, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    // Start stays high through RUN with changed operands: must be ignored in flight.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    a     = 8'h20;
    b     = 8'h03;
    @(posedge clk);
    #1;
    a = 8'h01;
    b = 8'h01;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != WIDTH || result !== 8'h23 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got latency=%0d result=%h cout=%b, want %0d 23 0",
               n, result, carry_out, WIDTH);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != WIDTH + 1 || result !== 8'h02 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got spacing=%0d result=%h cout=%b, want %0d 02 0",
               n, result, carry_out, WIDTH + 1);
    end
  endtask

  task automatic test_abort();
    bit seen;
    issue(1'b0, 8'h12, 8'h34);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h02 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b done=%b result=%h cout=%b, want 0 0 02 0",
               busy, done, result, carry_out);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_quiet: got activity=1 after abort, want 0");
    end
  endtask

  task automatic test_reset_mid_run();
    issue(1'b1, 8'h55, 8'h11);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry_out !== 1'b0 ||
        fa_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got busy=%b done=%b result=%h cout=%b fa_cin=%b, want 0",
               busy, done, result, carry_out, fa_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_op("after_reset", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
    test_op("add_ovf", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    test_op("sub", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    test_op("sub_borrow", 1'b1, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0);
    test_back_to_back();
    test_abort();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
